hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: decode/execute hazard sources in, stall/flush/PC control out.
interface hazard_scoreboard_if #(
    parameter int unsigned RW = 5
);
    logic          ID_EX_MemRead;
    logic [RW-1:0] ID_EX_Rd;
    logic          IF_ID_Valid;
    logic [RW-1:0] IF_ID_Rs1;
    logic [RW-1:0] IF_ID_Rs2;
    logic          IF_ID_Rs1_Used;
    logic          IF_ID_Rs2_Used;
    logic          IF_ID_Long;
    logic [RW-1:0] IF_ID_Rd;
    logic          WB_Long_Valid;
    logic [RW-1:0] WB_Long_Rd;
    logic          Branchflag;
    logic          EXE_MEM_Branch;
    logic          EXE_MEM_Jump;
    logic          EXE_MEM_Jalr;
    logic          ID_Interrupt_Confirm;
    logic          ID_Interrupt_Confirm_Timer;
    logic          MEM_MRET;
    logic          AXI_Stall;
    logic          Hazard_Stall;
    logic          Hazard_Flush;
    logic [2:0]    PcSel;
    logic          Sb_Full;
    logic [31:0]   Stall_Count;

    modport master (
        output ID_EX_MemRead, ID_EX_Rd, IF_ID_Valid, IF_ID_Rs1, IF_ID_Rs2,
               IF_ID_Rs1_Used, IF_ID_Rs2_Used, IF_ID_Long, IF_ID_Rd,
               WB_Long_Valid, WB_Long_Rd, Branchflag, EXE_MEM_Branch,
               EXE_MEM_Jump, EXE_MEM_Jalr, ID_Interrupt_Confirm,
               ID_Interrupt_Confirm_Timer, MEM_MRET, AXI_Stall,
        input  Hazard_Stall, Hazard_Flush, PcSel, Sb_Full, Stall_Count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rd, IF_ID_Valid, IF_ID_Rs1, IF_ID_Rs2,
               IF_ID_Rs1_Used, IF_ID_Rs2_Used, IF_ID_Long, IF_ID_Rd,
               WB_Long_Valid, WB_Long_Rd, Branchflag, EXE_MEM_Branch,
               EXE_MEM_Jump, EXE_MEM_Jalr, ID_Interrupt_Confirm,
               ID_Interrupt_Confirm_Timer, MEM_MRET, AXI_Stall,
        output Hazard_Stall, Hazard_Flush, PcSel, Sb_Full, Stall_Count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit: load-use and long-latency scoreboard stalls, structural stall on a full
// scoreboard, redirect flush with programmable length, next-PC select, stall statistics.
module hazard_scoreboard #(
    parameter int unsigned RW        = 5,
    parameter int unsigned MAX_PEND  = 4,
    parameter int unsigned FLUSH_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave hz
);
    localparam int unsigned NREG = 1 << RW;
    localparam int unsigned PW   = 4;
    localparam int unsigned FW   = 2;

    logic [NREG-1:0] busy_q, busy_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic sb_full;
    logic load_use, sb_stall, struct_stall;
    logic rs1_busy, rs2_busy;
    logic br_taken, redirect;
    logic flush_c, stall_c, issue, wb_dec;
    logic [2:0] pcsel_c;

    assign sb_full = rst && (pend_q == PW'(MAX_PEND));

    // Source-operand hazards; a same-cycle writeback to the source bypasses the busy bit.
    always_comb begin
        load_use = hz.ID_EX_MemRead && (hz.ID_EX_Rd != '0) &&
                   ((hz.IF_ID_Rs1_Used && (hz.IF_ID_Rs1 == hz.ID_EX_Rd)) ||
                    (hz.IF_ID_Rs2_Used && (hz.IF_ID_Rs2 == hz.ID_EX_Rd)));
        rs1_busy = hz.IF_ID_Rs1_Used && busy_q[hz.IF_ID_Rs1] &&
                   !(hz.WB_Long_Valid && (hz.WB_Long_Rd == hz.IF_ID_Rs1));
        rs2_busy = hz.IF_ID_Rs2_Used && busy_q[hz.IF_ID_Rs2] &&
                   !(hz.WB_Long_Valid && (hz.WB_Long_Rd == hz.IF_ID_Rs2));
        sb_stall     = rs1_busy || rs2_busy;
        struct_stall = hz.IF_ID_Valid && hz.IF_ID_Long && sb_full;
    end

    // Redirects: flush, PC select; both suppressed during reset and bus freeze.
    always_comb begin
        br_taken = hz.EXE_MEM_Branch && hz.Branchflag;
        redirect = br_taken || hz.EXE_MEM_Jump || hz.EXE_MEM_Jalr ||
                   hz.ID_Interrupt_Confirm || hz.ID_Interrupt_Confirm_Timer ||
                   hz.MEM_MRET;
        flush_c  = rst && !hz.AXI_Stall && (redirect || (flush_q != '0));
        stall_c  = rst && !hz.AXI_Stall && !flush_c && hz.IF_ID_Valid &&
                   (load_use || sb_stall || struct_stall);
        pcsel_c  = 3'b000;
        if (rst && !hz.AXI_Stall) begin
            if (hz.MEM_MRET)
                pcsel_c = 3'b100;
            else if (br_taken)
                pcsel_c = 3'b001;
            else if (hz.EXE_MEM_Jump || hz.EXE_MEM_Jalr)
                pcsel_c = 3'b010;
            else if (hz.ID_Interrupt_Confirm || hz.ID_Interrupt_Confirm_Timer)
                pcsel_c = 3'b011;
        end
        issue  = hz.IF_ID_Valid && hz.IF_ID_Long && !stall_c && !flush_c && !hz.AXI_Stall;
        wb_dec = hz.WB_Long_Valid && (pend_q != '0);
    end

    assign hz.Hazard_Stall = stall_c;
    assign hz.Hazard_Flush = flush_c;
    assign hz.PcSel        = pcsel_c;
    assign hz.Sb_Full      = sb_full;
    assign hz.Stall_Count  = stall_cnt_q;

    // Next-state: writeback clears apply even while frozen; an issue to the same register wins.
    always_comb begin
        busy_d      = busy_q;
        pend_d      = pend_q;
        flush_d     = flush_q;
        stall_cnt_d = stall_cnt_q;

        if (hz.WB_Long_Valid)
            busy_d[hz.WB_Long_Rd] = 1'b0;
        if (issue)
            busy_d[hz.IF_ID_Rd] = 1'b1;
        busy_d[0] = 1'b0;

        if (issue && !wb_dec)
            pend_d = pend_q + PW'(1);
        else if (!issue && wb_dec)
            pend_d = pend_q - PW'(1);

        if (!hz.AXI_Stall) begin
            if (redirect)
                flush_d = FW'(FLUSH_CYC - 1);
            else if (flush_q != '0)
                flush_d = flush_q - FW'(1);
        end

        if (stall_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= '0;
            pend_q      <= '0;
            flush_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: dut_a (MAX_PEND=2, FLUSH_CYC=3), dut_b (defaults).
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_scoreboard_if #(.RW(5)) ia ();
    hazard_scoreboard_if #(.RW(5)) ib ();

    hazard_scoreboard #(.RW(5), .MAX_PEND(2), .FLUSH_CYC(3)) dut_a (
        .clk(clk), .rst(rst), .hz(ia)
    );
    hazard_scoreboard #(.RW(5), .MAX_PEND(4), .FLUSH_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .hz(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ia.ID_EX_MemRead = 0; ia.ID_EX_Rd = 0; ia.IF_ID_Valid = 0;
        ia.IF_ID_Rs1 = 0; ia.IF_ID_Rs2 = 0; ia.IF_ID_Rs1_Used = 0; ia.IF_ID_Rs2_Used = 0;
        ia.IF_ID_Long = 0; ia.IF_ID_Rd = 0; ia.WB_Long_Valid = 0; ia.WB_Long_Rd = 0;
        ia.Branchflag = 0; ia.EXE_MEM_Branch = 0; ia.EXE_MEM_Jump = 0; ia.EXE_MEM_Jalr = 0;
        ia.ID_Interrupt_Confirm = 0; ia.ID_Interrupt_Confirm_Timer = 0; ia.MEM_MRET = 0;
        ia.AXI_Stall = 0;
        ib.ID_EX_MemRead = 0; ib.ID_EX_Rd = 0; ib.IF_ID_Valid = 0;
        ib.IF_ID_Rs1 = 0; ib.IF_ID_Rs2 = 0; ib.IF_ID_Rs1_Used = 0; ib.IF_ID_Rs2_Used = 0;
        ib.IF_ID_Long = 0; ib.IF_ID_Rd = 0; ib.WB_Long_Valid = 0; ib.WB_Long_Rd = 0;
        ib.Branchflag = 0; ib.EXE_MEM_Branch = 0; ib.EXE_MEM_Jump = 0; ib.EXE_MEM_Jalr = 0;
        ib.ID_Interrupt_Confirm = 0; ib.ID_Interrupt_Confirm_Timer = 0; ib.MEM_MRET = 0;
        ib.AXI_Stall = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        ia.MEM_MRET = 1; ia.ID_EX_MemRead = 1; ia.ID_EX_Rd = 5;
        ia.IF_ID_Valid = 1; ia.IF_ID_Rs1 = 5; ia.IF_ID_Rs1_Used = 1; ia.IF_ID_Long = 1;
        ib.EXE_MEM_Jump = 1; ib.IF_ID_Valid = 1; ib.IF_ID_Long = 1; ib.IF_ID_Rd = 3;
        cyc(); cyc();
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", ia.Hazard_Stall); end
        total++; if (ia.Hazard_Flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %0b want 0", ia.Hazard_Flush); end
        total++; if (ia.PcSel !== 3'b000) begin bad++; $display("FAIL rst_pcsel: got %b want 000", ia.PcSel); end
        total++; if (ia.Sb_Full !== 1'b0) begin bad++; $display("FAIL rst_sbfull: got %0b want 0", ia.Sb_Full); end
        total++; if (ia.Stall_Count !== 32'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", ia.Stall_Count); end
        total++; if (ib.PcSel !== 3'b000) begin bad++; $display("FAIL rst_pcsel_b: got %b want 000", ib.PcSel); end
        total++; if (ib.Hazard_Flush !== 1'b0) begin bad++; $display("FAIL rst_flush_b: got %0b want 0", ib.Hazard_Flush); end
        idle();
        cyc();
        rst = 1;
        cyc();
    endtask

    task automatic test_load_use();
        logic [31:0] sc0;
        sc0 = ia.Stall_Count;
        ia.ID_EX_MemRead = 1; ia.ID_EX_Rd = 5;
        ia.IF_ID_Valid = 1; ia.IF_ID_Rs1 = 5; ia.IF_ID_Rs1_Used = 1;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %0b want 1", ia.Hazard_Stall); end
        cyc();
        ia.ID_EX_MemRead = 0;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %0b want 0", ia.Hazard_Stall); end
        total++; if (ia.Stall_Count !== sc0 + 32'd1) begin bad++; $display("FAIL lu_count: got %0d want %0d", ia.Stall_Count, sc0 + 32'd1); end
        ia.ID_EX_MemRead = 1; ia.ID_EX_Rd = 0; ia.IF_ID_Rs1 = 0;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL lu_rd0: got %0b want 0", ia.Hazard_Stall); end
        ia.ID_EX_Rd = 5; ia.IF_ID_Rs1 = 5; ia.IF_ID_Rs1_Used = 0; ia.IF_ID_Rs2 = 5; ia.IF_ID_Rs2_Used = 0;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL lu_unused: got %0b want 0", ia.Hazard_Stall); end
        ia.IF_ID_Rs2_Used = 1;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b1) begin bad++; $display("FAIL lu_rs2: got %0b want 1", ia.Hazard_Stall); end
        ia.IF_ID_Valid = 0;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL lu_invalid: got %0b want 0", ia.Hazard_Stall); end
        idle();
        cyc();
    endtask

    task automatic test_long_op();
        logic [31:0] sc0;
        ia.IF_ID_Valid = 1; ia.IF_ID_Long = 1; ia.IF_ID_Rd = 7;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL long_issue: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        ia.IF_ID_Long = 0; ia.IF_ID_Rd = 0; ia.IF_ID_Rs2 = 7; ia.IF_ID_Rs2_Used = 1;
        sc0 = ia.Stall_Count;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ia.Hazard_Stall !== 1'b1) begin bad++; $display("FAIL long_wait%0d: got %0b want 1", i, ia.Hazard_Stall); end
            cyc();
        end
        ia.WB_Long_Valid = 1; ia.WB_Long_Rd = 7;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL long_bypass: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        ia.WB_Long_Valid = 0; ia.WB_Long_Rd = 0;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL long_cleared: got %0b want 0", ia.Hazard_Stall); end
        total++; if (ia.Stall_Count !== sc0 + 32'd3) begin bad++; $display("FAIL long_count: got %0d want %0d", ia.Stall_Count, sc0 + 32'd3); end
        idle();
        cyc();
    endtask

    task automatic test_structural();
        ia.IF_ID_Valid = 1; ia.IF_ID_Long = 1; ia.IF_ID_Rd = 3;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL st_issue1: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        ia.IF_ID_Rd = 4;
        #1;
        total++; if (ia.Sb_Full !== 1'b0) begin bad++; $display("FAIL st_full1: got %0b want 0", ia.Sb_Full); end
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL st_issue2: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        ia.IF_ID_Rd = 6;
        #1;
        total++; if (ia.Sb_Full !== 1'b1) begin bad++; $display("FAIL st_full2: got %0b want 1", ia.Sb_Full); end
        total++; if (ia.Hazard_Stall !== 1'b1) begin bad++; $display("FAIL st_stall3: got %0b want 1", ia.Hazard_Stall); end
        cyc();
        ia.WB_Long_Valid = 1; ia.WB_Long_Rd = 3;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b1) begin bad++; $display("FAIL st_stall_wb: got %0b want 1", ia.Hazard_Stall); end
        cyc();
        ia.WB_Long_Valid = 0;
        #1;
        total++; if (ia.Sb_Full !== 1'b0) begin bad++; $display("FAIL st_after_wb: got %0b want 0", ia.Sb_Full); end
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL st_issue3: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        idle();
        ia.WB_Long_Valid = 1; ia.WB_Long_Rd = 4;
        #1;
        total++; if (ia.Sb_Full !== 1'b1) begin bad++; $display("FAIL st_refull: got %0b want 1", ia.Sb_Full); end
        cyc();
        ia.WB_Long_Rd = 6;
        #1;
        total++; if (ia.Sb_Full !== 1'b0) begin bad++; $display("FAIL st_drain: got %0b want 0", ia.Sb_Full); end
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_priority();
        logic [6:0] vec [8];
        logic [2:0] exp_sel [8];
        // {mret, branch, branchflag, jump, jalr, irq, irq_timer}
        vec[0] = 7'b1110000; exp_sel[0] = 3'b100;
        vec[1] = 7'b0110000; exp_sel[1] = 3'b001;
        vec[2] = 7'b0111100; exp_sel[2] = 3'b001;
        vec[3] = 7'b0100100; exp_sel[3] = 3'b010;
        vec[4] = 7'b0000110; exp_sel[4] = 3'b010;
        vec[5] = 7'b0000001; exp_sel[5] = 3'b011;
        vec[6] = 7'b0010000; exp_sel[6] = 3'b000;
        vec[7] = 7'b1000011; exp_sel[7] = 3'b100;
        ia.ID_EX_MemRead = 1; ia.ID_EX_Rd = 5;
        ia.IF_ID_Valid = 1; ia.IF_ID_Rs1 = 5; ia.IF_ID_Rs1_Used = 1;
        for (int i = 0; i < 8; i++) begin
            {ia.MEM_MRET, ia.EXE_MEM_Branch, ia.Branchflag, ia.EXE_MEM_Jump,
             ia.EXE_MEM_Jalr, ia.ID_Interrupt_Confirm, ia.ID_Interrupt_Confirm_Timer} = vec[i];
            #1;
            total++; if (ia.PcSel !== exp_sel[i]) begin bad++; $display("FAIL prio_pcsel%0d: got %b want %b", i, ia.PcSel, exp_sel[i]); end
            total++; if (ia.Hazard_Flush !== 1'b1) begin bad++; $display("FAIL prio_flush%0d: got %0b want 1", i, ia.Hazard_Flush); end
            total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL prio_stall%0d: got %0b want 0", i, ia.Hazard_Stall); end
            cyc();
        end
        idle();
        repeat (3) cyc();
    endtask

    task automatic test_flush();
        logic exp1 [5];
        exp1[0] = 1; exp1[1] = 1; exp1[2] = 1; exp1[3] = 0; exp1[4] = 0;
        // plain jump: three flush cycles; load-use in ID must not stall while flushing
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) ia.EXE_MEM_Jump = 1;
            ia.ID_EX_MemRead = 1; ia.ID_EX_Rd = 8; ia.IF_ID_Valid = 1;
            ia.IF_ID_Rs1 = 8; ia.IF_ID_Rs1_Used = 1;
            #1;
            total++; if (ia.Hazard_Flush !== exp1[i]) begin bad++; $display("FAIL fl_jump%0d: got %0b want %0b", i, ia.Hazard_Flush, exp1[i]); end
            total++; if (ia.Hazard_Stall !== !exp1[i]) begin bad++; $display("FAIL fl_stall%0d: got %0b want %0b", i, ia.Hazard_Stall, !exp1[i]); end
            cyc();
        end
        idle();
        cyc();
        // branch one cycle after jump reloads the countdown
        exp1[3] = 1;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) ia.EXE_MEM_Jump = 1;
            if (i == 1) begin ia.EXE_MEM_Branch = 1; ia.Branchflag = 1; end
            #1;
            total++; if (ia.Hazard_Flush !== exp1[i]) begin bad++; $display("FAIL fl_reload%0d: got %0b want %0b", i, ia.Hazard_Flush, exp1[i]); end
            if (i == 1) begin
                total++; if (ia.PcSel !== 3'b001) begin bad++; $display("FAIL fl_reload_sel: got %b want 001", ia.PcSel); end
            end
            cyc();
        end
        idle();
        cyc();
        // bus freeze mid-countdown: flush drops, countdown holds
        exp1[0] = 1; exp1[1] = 1; exp1[2] = 0; exp1[3] = 1; exp1[4] = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) ia.EXE_MEM_Jump = 1;
            if (i == 2) begin ia.AXI_Stall = 1; ia.EXE_MEM_Jalr = 1; end
            #1;
            total++; if (ia.Hazard_Flush !== exp1[i]) begin bad++; $display("FAIL fl_axi%0d: got %0b want %0b", i, ia.Hazard_Flush, exp1[i]); end
            if (i == 2) begin
                total++; if (ia.PcSel !== 3'b000) begin bad++; $display("FAIL fl_axi_sel: got %b want 000", ia.PcSel); end
            end
            cyc();
        end
        idle();
        cyc();
    endtask

    task automatic test_axi_wb();
        logic [31:0] sc0;
        ia.IF_ID_Valid = 1; ia.IF_ID_Long = 1; ia.IF_ID_Rd = 9;
        cyc();
        ia.AXI_Stall = 1; ia.IF_ID_Rd = 10; ia.IF_ID_Rs1 = 9; ia.IF_ID_Rs1_Used = 1;
        ia.WB_Long_Valid = 1; ia.WB_Long_Rd = 9;
        sc0 = ia.Stall_Count;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL axi_stall: got %0b want 0", ia.Hazard_Stall); end
        cyc();
        idle();
        ia.IF_ID_Valid = 1; ia.IF_ID_Rs1 = 9; ia.IF_ID_Rs1_Used = 1;
        ia.IF_ID_Rs2 = 10; ia.IF_ID_Rs2_Used = 1; ia.IF_ID_Long = 1; ia.IF_ID_Rd = 11;
        #1;
        total++; if (ia.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL axi_frozen_set: got %0b want 0", ia.Hazard_Stall); end
        total++; if (ia.Stall_Count !== sc0) begin bad++; $display("FAIL axi_count: got %0d want %0d", ia.Stall_Count, sc0); end
        cyc();
        idle();
        ia.WB_Long_Valid = 1; ia.WB_Long_Rd = 11;
        #1;
        total++; if (ia.Sb_Full !== 1'b0) begin bad++; $display("FAIL axi_wb_credit: got %0b want 0", ia.Sb_Full); end
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_reset_pending();
        for (int i = 1; i <= 3; i++) begin
            ib.IF_ID_Valid = 1; ib.IF_ID_Long = 1; ib.IF_ID_Rd = 5'(i);
            cyc();
        end
        idle();
        rst = 0;
        #1;
        total++; if (ib.Sb_Full !== 1'b0) begin bad++; $display("FAIL rp_full3: got %0b want 0", ib.Sb_Full); end
        cyc();
        rst = 1;
        ib.WB_Long_Valid = 1; ib.WB_Long_Rd = 1;
        cyc();
        idle();
        ib.IF_ID_Valid = 1; ib.IF_ID_Rs1 = 2; ib.IF_ID_Rs1_Used = 1;
        ib.IF_ID_Rs2 = 3; ib.IF_ID_Rs2_Used = 1;
        #1;
        total++; if (ib.Hazard_Stall !== 1'b0) begin bad++; $display("FAIL rp_busy_clear: got %0b want 0", ib.Hazard_Stall); end
        idle();
        for (int i = 4; i <= 7; i++) begin
            ib.IF_ID_Valid = 1; ib.IF_ID_Long = 1; ib.IF_ID_Rd = 5'(i);
            #1;
            total++; if (ib.Sb_Full !== 1'b0) begin bad++; $display("FAIL rp_fill%0d: got %0b want 0", i, ib.Sb_Full); end
            cyc();
        end
        idle();
        #1;
        total++; if (ib.Sb_Full !== 1'b1) begin bad++; $display("FAIL rp_full4: got %0b want 1", ib.Sb_Full); end
        total++; if (ib.Stall_Count !== 32'd0) begin bad++; $display("FAIL rp_count: got %0d want 0", ib.Stall_Count); end
        cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 0;
        idle();
        test_reset();
        test_load_use();
        test_long_op();
        test_structural();
        test_priority();
        test_flush();
        test_axi_wb();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
